dac_update_arbiter: RTL and testbench

DAC_UPDATE_ARBITER -- requirements
Module: dac_update_arbiter

---
 rtl/dac_update_arbiter.sv | 74 +++++++
 tb/tb_dac_update_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dac_update_arbiter.sv
// dac_update_arbiter: round-robin arbiter feeding one DAC from two requesters.
module dac_update_arbiter #(
  parameter int DW     = 10,
  parameter int SETTLE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] dac_d,
  output logic          dac_en,
  output logic          busy,
  output logic          grant_id,
  output logic [15:0]   update_cnt
);
  typedef enum logic {S_IDLE, S_SETTLE} state_t;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_last;
  logic [DW-1:0] r_dac_d;
  logic          r_dac_en;
  logic          r_gid;
  logic [15:0]   r_upd;
  logic          w_open;
  logic          w_win1;
  logic          w_hs;
  logic [DW-1:0] w_data;
  // Grants open only in IDLE with en; on contention the requester not granted last wins
  always_comb begin
    w_open     = en && (r_state == S_IDLE);
    w_win1     = req1_valid && (!req0_valid || !r_last);
    req1_ready = w_open && w_win1;
    req0_ready = w_open && req0_valid && !w_win1;
    w_hs       = req0_ready || req1_ready;
    w_data     = w_win1 ? req1_data : req0_data;
  end
  // Load DAC on handshake, then hold for SETTLE cycles before the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_dac_d  <= '0;
      r_dac_en <= 1'b0;
      r_gid    <= 1'b0;
      r_upd    <= '0;
    end else if (!en) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dac_en <= 1'b0;
    end else if (w_hs) begin
      r_state  <= S_SETTLE;
      r_cnt    <= 8'(SETTLE - 1);
      r_last   <= w_win1;
      r_gid    <= w_win1;
      r_dac_d  <= w_data;
      r_dac_en <= 1'b1;
      r_upd    <= r_upd + 16'd1;
    end else if (r_state == S_SETTLE) begin
      r_state <= (r_cnt == 8'd0) ? S_IDLE : S_SETTLE;
      r_cnt   <= (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
    end
  end
  assign dac_d      = r_dac_d;
  assign dac_en     = r_dac_en;
  assign busy       = (r_state == S_SETTLE);
  assign grant_id   = r_gid;
  assign update_cnt = r_upd;
endmodule

// File: tb/tb_dac_update_arbiter.sv
// tb_dac_update_arbiter: directed checks of grants, settle spacing, en and reset behaviour.
module tb_dac_update_arbiter;
  localparam int DW = 10;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic [DW-1:0] dac_d;
  logic          dac_en;
  logic          busy;
  logic          grant_id;
  logic [15:0]   update_cnt;
  int n_chk = 0;
  int n_fail = 0;

  dac_update_arbiter #(.DW(DW), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dac_d(dac_d), .dac_en(dac_en), .busy(busy), .grant_id(grant_id), .update_cnt(update_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_chk++; if (dac_d !== '0) begin n_fail++; $display("FAIL reset_dac_d got %h exp 0", dac_d); end
    n_chk++; if (dac_en !== 1'b0) begin n_fail++; $display("FAIL reset_dac_en got %b exp 0", dac_en); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got %b exp 0", grant_id); end
    n_chk++; if (update_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_update_cnt got %0d exp 0", update_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    en = 1'b1; req0_valid = 1'b1; req0_data = 10'h155;
    #1;
    n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_r0_ready got %b exp 1", req0_ready); end
    n_chk++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_r1_ready got %b exp 0", req1_ready); end
    step();
    n_chk++; if (dac_d !== 10'h155) begin n_fail++; $display("FAIL single_dac_d got %h exp 155", dac_d); end
    n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant got %b exp 0", grant_id); end
    n_chk++; if (dac_en !== 1'b1) begin n_fail++; $display("FAIL single_dac_en got %b exp 1", dac_en); end
    n_chk++; if (update_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", update_cnt); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
  endtask

  task automatic test_hold_spacing();
    for (int c = 1; c <= 11; c++) begin
      logic e_rdy;
      logic [15:0] e_cnt;
      e_rdy = (c % 5 == 0);
      e_cnt = 16'((c - 1) / 5 + 1);
      n_chk++; if (req0_ready !== e_rdy) begin n_fail++; $display("FAIL spacing_ready c=%0d got %b exp %b", c, req0_ready, e_rdy); end
      n_chk++; if (update_cnt !== e_cnt) begin n_fail++; $display("FAIL spacing_cnt c=%0d got %0d exp %0d", c, update_cnt, e_cnt); end
      if (c < 11) step();
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    en = 1'b1;
    req0_valid = 1'b1; req0_data = 10'h0AA;
    req1_valid = 1'b1; req1_data = 10'h3FF;
    for (int k = 0; k < 4; k++) begin
      logic e1;
      logic [DW-1:0] e_d;
      e1 = (k % 2 == 1);
      e_d = e1 ? 10'h3FF : 10'h0AA;
      #1;
      n_chk++; if (req0_ready !== !e1) begin n_fail++; $display("FAIL rr_r0_ready k=%0d got %b exp %b", k, req0_ready, !e1); end
      n_chk++; if (req1_ready !== e1) begin n_fail++; $display("FAIL rr_r1_ready k=%0d got %b exp %b", k, req1_ready, e1); end
      step();
      n_chk++; if (grant_id !== e1) begin n_fail++; $display("FAIL rr_grant k=%0d got %b exp %b", k, grant_id, e1); end
      n_chk++; if (dac_d !== e_d) begin n_fail++; $display("FAIL rr_dac_d k=%0d got %h exp %h", k, dac_d, e_d); end
      n_chk++; if (update_cnt !== 16'(k + 1)) begin n_fail++; $display("FAIL rr_cnt k=%0d got %0d exp %0d", k, update_cnt, k + 1); end
      repeat (4) step();
    end
    do_reset();
  endtask

  task automatic test_en_drop();
    en = 1'b1; req0_valid = 1'b1; req0_data = 10'h123;
    step(); step();
    en = 1'b0;
    #1;
    n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL endrop_ready_settle got %b exp 0", req0_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy i=%0d got %b exp 0", i, busy); end
      n_chk++; if (dac_en !== 1'b0) begin n_fail++; $display("FAIL endrop_dac_en i=%0d got %b exp 0", i, dac_en); end
      n_chk++; if (dac_d !== 10'h123) begin n_fail++; $display("FAIL endrop_dac_d i=%0d got %h exp 123", i, dac_d); end
      n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL endrop_ready i=%0d got %b exp 0", i, req0_ready); end
    end
    en = 1'b1; req0_data = 10'h0F0;
    #1;
    n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL enback_ready got %b exp 1", req0_ready); end
    step();
    n_chk++; if (dac_d !== 10'h0F0) begin n_fail++; $display("FAIL enback_dac_d got %h exp 0f0", dac_d); end
    n_chk++; if (update_cnt !== 16'd2) begin n_fail++; $display("FAIL enback_cnt got %0d exp 2", update_cnt); end
    n_chk++; if (dac_en !== 1'b1) begin n_fail++; $display("FAIL enback_dac_en got %b exp 1", dac_en); end
    do_reset();
  endtask

  task automatic test_wrap();
    force dut.r_upd = 16'hFFFF;
    #1;
    release dut.r_upd;
    #1;
    n_chk++; if (update_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffff", update_cnt); end
    en = 1'b1; req1_valid = 1'b1; req1_data = 10'h201;
    step();
    n_chk++; if (update_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_cnt got %h exp 0", update_cnt); end
    n_chk++; if (dac_d !== 10'h201) begin n_fail++; $display("FAIL wrap_dac_d got %h exp 201", dac_d); end
    do_reset();
  endtask

  task automatic test_reset_mid_settle();
    en = 1'b1; req0_valid = 1'b1; req0_data = 10'h111;
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 10'h222;
    step();
    reset = 1'b1;
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_chk++; if (dac_d !== '0) begin n_fail++; $display("FAIL rstmid_dac_d got %h exp 0", dac_d); end
    n_chk++; if (dac_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_dac_en got %b exp 0", dac_en); end
    n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rstmid_grant got %b exp 0", grant_id); end
    n_chk++; if (update_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d exp 0", update_cnt); end
    step();
    n_chk++; if (update_cnt !== 16'd0) begin n_fail++; $display("FAIL rsths_cnt got %0d exp 0", update_cnt); end
    n_chk++; if (dac_d !== '0) begin n_fail++; $display("FAIL rsths_dac_d got %h exp 0", dac_d); end
    reset = 1'b0;
    #1;
    n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rstrel_r1_ready got %b exp 1", req1_ready); end
    n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rstrel_r0_ready got %b exp 0", req0_ready); end
    step();
    n_chk++; if (dac_d !== 10'h222) begin n_fail++; $display("FAIL rstrel_dac_d got %h exp 222", dac_d); end
    n_chk++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rstrel_grant got %b exp 1", grant_id); end
    n_chk++; if (update_cnt !== 16'd1) begin n_fail++; $display("FAIL rstrel_cnt got %0d exp 1", update_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_hold_spacing();
    test_round_robin();
    test_en_drop();
    test_wrap();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
